// File: rtl/signal_period_meter.sv
// Period meter for an asynchronous square wave: synchronizes i_signal, counts clocks between accepted rises.
// Define PERIOD_AVG_EN to report the running mean of the last four accepted periods instead of each one.
module signal_period_meter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned TIMEOUT    = 50_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_signal,
  output logic [WIDTH-1:0] o_periodo,
  output logic [WIDTH-1:0] o_resolucion,
  output logic             o_periodo_valid,
  output logic             o_timeout
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       MEASURE = 1'b1;
  localparam logic [WIDTH-1:0] MIN_P   = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] TO_LAST = WIDTH'(TIMEOUT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync_dly_q, sync_dly_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] periodo_q, periodo_d;
  logic [WIDTH-1:0] resol_q, resol_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             rise;
  logic             accept;
  logic             timeout_hit;
  logic [WIDTH-1:0] cnt_inc;

`ifdef PERIOD_AVG_EN
  logic [WIDTH-1:0] hist_q [4];
  logic [WIDTH-1:0] hist_d [4];
  logic [WIDTH+1:0] sum_q, sum_d;
  logic [WIDTH+1:0] avg_sum;
  logic [2:0]       fill_q, fill_d;
`endif

  always_comb begin
    sync1_d     = i_signal;
    sync2_d     = sync1_q;
    sync_dly_d  = sync2_q;
    rise        = sync2_q & ~sync_dly_q;
    cnt_inc     = cnt_q + 1'b1;
    timeout_hit = (state_q == MEASURE) && (cnt_q == TO_LAST);

    state_d   = state_q;
    cnt_d     = cnt_q;
    periodo_d = periodo_q;
    resol_d   = resol_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) state_d = MEASURE;
      end
      default: begin
        // Timeout has priority; a coincident rise becomes a fresh arming edge.
        if (timeout_hit) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          if (!rise) state_d = IDLE;
        end else if (rise && (cnt_inc >= MIN_P)) begin
          accept    = 1'b1;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase

`ifdef PERIOD_AVG_EN
    hist_d  = hist_q;
    sum_d   = sum_q;
    fill_d  = fill_q;
    // The oldest entry is always part of the sum, so the subtraction cannot underflow.
    avg_sum = sum_q - {2'b00, hist_q[3]} + {2'b00, cnt_inc};
    if (timeout_hit) begin
      hist_d = '{default: '0};
      sum_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d[3] = hist_q[2];
      hist_d[2] = hist_q[1];
      hist_d[1] = hist_q[0];
      hist_d[0] = cnt_inc;
      sum_d     = avg_sum;
      fill_d    = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
      if (fill_q >= 3'd3) begin
        periodo_d = avg_sum[WIDTH+1:2];
        resol_d   = avg_sum[WIDTH+1:2] >> 4;
        valid_d   = 1'b1;
      end
    end
`else
    if (accept) begin
      periodo_d = cnt_inc;
      resol_d   = cnt_inc >> 4;
      valid_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync_dly_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      periodo_q  <= '0;
      resol_q    <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync_dly_q <= sync_dly_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      periodo_q  <= periodo_d;
      resol_q    <= resol_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef PERIOD_AVG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= '{default: '0};
      sum_q  <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end
`endif

  assign o_periodo       = periodo_q;
  assign o_resolucion    = resol_q;
  assign o_periodo_valid = valid_q;
  assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_signal_period_meter.sv
// Directed bench for signal_period_meter with MIN_PERIOD=8, TIMEOUT=1000.
// Inputs change on the falling clock edge; outputs are sampled on the falling edge.
module tb_signal_period_meter;

  localparam int unsigned WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             i_signal;
  logic [WIDTH-1:0] o_periodo;
  logic [WIDTH-1:0] o_resolucion;
  logic             o_periodo_valid;
  logic             o_timeout;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int dbl = 0;
  int base;
  logic [31:0] last_p = '0;
  logic [31:0] last_r = '0;
  logic        prev_v = 1'b0;

  always #5 clock = ~clock;

  signal_period_meter #(
    .WIDTH     (WIDTH),
    .MIN_PERIOD(8),
    .TIMEOUT   (1000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .i_signal       (i_signal),
    .o_periodo      (o_periodo),
    .o_resolucion   (o_resolucion),
    .o_periodo_valid(o_periodo_valid),
    .o_timeout      (o_timeout)
  );

  always @(negedge clock) begin
    if (o_periodo_valid) begin
      strobes = strobes + 1;
      last_p  = o_periodo;
      last_r  = o_resolucion;
      if (prev_v) dbl = dbl + 1;
    end
    prev_v = o_periodo_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rise followed by hi cycles high and lo cycles low; consecutive calls space rises by hi+lo.
  task automatic pulse(input int hi, input int lo);
    i_signal = 1'b1;
    repeat (hi) @(negedge clock);
    i_signal = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    i_signal = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_periodo", o_periodo, 32'd0);
    check("rst_resol", o_resolucion, 32'd0);
    check("rst_valid", {31'd0, o_periodo_valid}, 32'd0);
    check("rst_timeout", {31'd0, o_timeout}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

`ifdef PERIOD_AVG_EN
    pulse(50, 50);
    pulse(52, 52);
    pulse(48, 48);
    pulse(50, 50);
    check("avg_no_early_strobe", strobes, 32'd0);
    pulse(54, 54);
    check("avg_first_count", strobes, 32'd1);
    check("avg_first_p", last_p, 32'd100);
    check("avg_first_r", last_r, 32'd6);
    pulse(50, 50);
    check("avg_second_count", strobes, 32'd2);
    check("avg_second_p", last_p, 32'd102);
    check("avg_second_r", last_r, 32'd6);
`else
    // Period 100: first rise only arms.
    repeat (4) pulse(50, 50);
    check("p100_count", strobes, 32'd3);
    check("p100_p", last_p, 32'd100);
    check("p100_r", last_r, 32'd6);

    // Change to period 37.
    base = strobes;
    pulse(18, 19);
    pulse(18, 19);
    check("p37_count", strobes - base, 32'd2);
    check("p37_p", last_p, 32'd37);
    check("p37_r", last_r, 32'd2);

    // Glitch 3 cycles after an accepted rise, inside a 100-cycle period.
    base = strobes;
    i_signal = 1'b1;
    @(negedge clock);
    i_signal = 1'b0;
    repeat (2) @(negedge clock);
    i_signal = 1'b1;
    @(negedge clock);
    i_signal = 1'b0;
    repeat (96) @(negedge clock);
    pulse(50, 50);
    check("glitch_count", strobes - base, 32'd2);
    check("glitch_p", last_p, 32'd100);

    // Input stops: timeout after 1000 cycles without an accepted rise.
    base = strobes;
    repeat (800) @(negedge clock);
    check("to_not_early", {31'd0, o_timeout}, 32'd0);
    repeat (200) @(negedge clock);
    check("to_set", {31'd0, o_timeout}, 32'd1);
    check("to_hold_p", o_periodo, 32'd100);
    check("to_hold_r", o_resolucion, 32'd6);
    check("to_no_strobe", strobes - base, 32'd0);
    pulse(50, 50);
    check("to_arm_no_strobe", strobes - base, 32'd0);
    check("to_arm_still_set", {31'd0, o_timeout}, 32'd1);
    pulse(50, 50);
    check("to_recover_count", strobes - base, 32'd1);
    check("to_recover_p", last_p, 32'd100);
    check("to_cleared", {31'd0, o_timeout}, 32'd0);

    // Reset 40 cycles into a measurement, with the input low.
    pulse(50, 50);
    i_signal = 1'b1;
    repeat (30) @(negedge clock);
    i_signal = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_p", o_periodo, 32'd0);
    check("mid_rst_r", o_resolucion, 32'd0);
    check("mid_rst_timeout", {31'd0, o_timeout}, 32'd0);
    check("mid_rst_valid", {31'd0, o_periodo_valid}, 32'd0);
    repeat (60) @(negedge clock);
    base = strobes;
    pulse(50, 50);
    check("mid_rst_arm", strobes - base, 32'd0);
    pulse(50, 50);
    check("mid_rst_count", strobes - base, 32'd1);
    check("mid_rst_after_p", last_p, 32'd100);
    check("mid_rst_after_r", last_r, 32'd6);
`endif

    check("no_double_strobe", dbl, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
